// File: rtl/cell_window_builder.sv
// cell_window_builder: raster RGB pixel stream in, packed 3x3 cells out (one per interior centre).
// Latency: cell appears 1 cycle after the handshake of the pixel that completes its window.
// Backpressure: single output register, in_ready = !out_valid || out_ready; stalls input while a cell waits.
// Optional build macro CELL_WINDOW_FRAME_ERR_EN adds frame_err pulse and err_count for truncated frames.
module cell_window_builder #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CH_W   = 8,
  parameter int CH_NUM = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic [CH_W*CH_NUM-1:0]          in_pixel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [9*CH_W*CH_NUM-1:0]        out_cell,
  output logic [$clog2(IMG_W)-1:0]        out_x,
  output logic [$clog2(IMG_H)-1:0]        out_y,
  output logic                            frame_done
`ifdef CELL_WINDOW_FRAME_ERR_EN
  ,
  output logic                            frame_err,
  output logic [15:0]                     err_count
`endif
);

  localparam int PIX_W  = CH_W * CH_NUM;
  localparam int CELL_W = 9 * PIX_W;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_MIN  = XW'(2);
  localparam logic [YW-1:0] ROW_MIN  = YW'(2);
  localparam logic [XW-1:0] X_FINAL  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_FINAL  = YW'(IMG_H - 2);

  // Position of the next pixel to be accepted
  logic [XW-1:0] colCnt;
  logic [YW-1:0] rowCnt;

  // Effective position of the pixel on the input port (in_sof forces 0,0)
  logic [XW-1:0] curCol;
  logic [YW-1:0] curRow;
  logic          pixAcc;
  logic          emitNow;

  // Line memories: line1 holds the previous row, line2 the row before it
  logic [PIX_W-1:0] line1Mem [IMG_W];
  logic [PIX_W-1:0] line2Mem [IMG_W];
  logic [PIX_W-1:0] line1Rd;
  logic [PIX_W-1:0] line2Rd;

  // 3x3 window, [row][col], row 0 = top, col 0 = oldest
  logic [PIX_W-1:0] win     [3][3];
  logic [PIX_W-1:0] winNext [3][3];
  logic [CELL_W-1:0] cellNext;

  assign in_ready = !out_valid || out_ready;
  assign pixAcc   = in_valid && in_ready;
  assign curCol   = in_sof ? '0 : colCnt;
  assign curRow   = in_sof ? '0 : rowCnt;
  assign line1Rd  = line1Mem[curCol];
  assign line2Rd  = line2Mem[curCol];
  // Columns 0 and 1 still hold the tail of the previous line, so they never emit
  assign emitNow  = (curCol >= COL_MIN) && (curRow >= ROW_MIN);

  // Window after this pixel's shift: old columns move left, new column enters at the right
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      winNext[r][0] = win[r][1];
      winNext[r][1] = win[r][2];
      winNext[r][2] = '0;
    end
    winNext[0][2] = line2Rd;
    winNext[1][2] = line1Rd;
    winNext[2][2] = in_pixel;
  end

  // Pack the shifted window, k = r*3 + c
  always_comb begin
    cellNext = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cellNext[(r*3 + c)*PIX_W +: PIX_W] = winNext[r][c];
      end
    end
  end

  // Line memories are not reset; the row counter keeps stale contents out of emitted cells
  always_ff @(posedge clk) begin
    if (pixAcc) begin
      line1Mem[curCol] <= in_pixel;
      line2Mem[curCol] <= line1Rd;
    end
  end

  // Raster position counters, restarted by an accepted in_sof
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colCnt <= '0;
      rowCnt <= '0;
    end else if (pixAcc) begin
      if (curCol == COL_LAST) begin
        colCnt <= '0;
        rowCnt <= (curRow == ROW_LAST) ? '0 : curRow + 1'b1;
      end else begin
        colCnt <= curCol + 1'b1;
        rowCnt <= curRow;
      end
    end
  end

  // Window shift register, advances once per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (pixAcc) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= winNext[r][c];
        end
      end
    end
  end

  // Output register: load on an emitting pixel, hold until taken, clear when taken with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cell  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (pixAcc && emitNow) begin
      out_valid <= 1'b1;
      out_cell  <= cellNext;
      out_x     <= curCol - 1'b1;
      out_y     <= curRow - 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pulse after the last interior cell of the frame is taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && (out_x == X_FINAL) && (out_y == Y_FINAL);
    end
  end

`ifdef CELL_WINDOW_FRAME_ERR_EN
  // Flag and count an in_sof that arrives before the current frame finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      if (pixAcc && in_sof && ((colCnt != '0) || (rowCnt != '0))) begin
        frame_err <= 1'b1;
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cell_window_builder.sv
// Directed bench for cell_window_builder on a 4x4 image.
// Covers reset, latency, backpressure hold, back-to-back frames, early in_sof, mid-frame reset, random handshakes.
module tb_cell_window_builder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 24;
  localparam int CW = 216;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_cell;
  logic [1:0]    out_x;
  logic [1:0]    out_y;
  logic          frame_done;
`ifdef CELL_WINDOW_FRAME_ERR_EN
  logic          frame_err;
  logic [15:0]   err_count;
`endif

  always #5 clk = ~clk;

  cell_window_builder #(.IMG_W(W), .IMG_H(H), .CH_W(8), .CH_NUM(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cell  (out_cell),
    .out_x     (out_x),
    .out_y     (out_y),
    .frame_done(frame_done)
`ifdef CELL_WINDOW_FRAME_ERR_EN
    ,
    .frame_err (frame_err),
    .err_count (err_count)
`endif
  );

  int nCompared   = 0;
  int nMismatched = 0;

  int            qx[$];
  int            qy[$];
  logic [CW-1:0] qcell[$];
  int            fdPos[$];
  int            errPulses = 0;
  bit            drvDone;
  logic [CW-1:0] firstCell;

  // Record every cell handshake and every frame_done / frame_err pulse
  always @(negedge clk) begin
    if (frame_done) fdPos.push_back(qcell.size());
`ifdef CELL_WINDOW_FRAME_ERR_EN
    if (frame_err) errPulses++;
`endif
    if (out_valid && out_ready) begin
      qx.push_back(int'(out_x));
      qy.push_back(int'(out_y));
      qcell.push_back(out_cell);
    end
  end

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pixOf(input int base, input int x, input int y, input bit mix);
    logic [7:0] v;
    v = 8'(base + y*16 + x);
    return mix ? {~v, v ^ 8'h5A, v} : {v, v, v};
  endfunction

  function automatic logic [CW-1:0] cellOf(input int base, input int x, input int y, input bit mix);
    logic [CW-1:0] c;
    c = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        c[(r*3 + k)*PW +: PW] = pixOf(base, x - 1 + k, y - 1 + r, mix);
    return c;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send raster pixels first..last of one frame; optional random idle cycles between pixels
  task automatic sendRange(input int base, input int first, input int last, input bit sofFirst,
                           input bit mix, input bit gaps);
    for (int i = first; i <= last; i++) begin
      int guard;
      bit took;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_pixel = pixOf(base, i % W, i / W, mix);
      in_sof   = sofFirst && (i == first);
      took  = 1'b0;
      guard = 0;
      while (!took && guard < 100) begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!took) checkVal("in_ready_timeout", took, 1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic clearMon();
    qx.delete();
    qy.delete();
    qcell.delete();
    fdPos.delete();
    errPulses = 0;
  endtask

  // Compare the four cells of one 4x4 frame starting at queue index startIdx
  task automatic checkFrameCells(input string tag, input int startIdx, input int base, input bit mix);
    for (int yy = 1; yy <= 2; yy++) begin
      for (int xx = 1; xx <= 2; xx++) begin
        int n;
        n = startIdx + (yy - 1)*2 + (xx - 1);
        if (n < qcell.size()) begin
          checkVal({tag, "_x"}, qx[n], xx);
          checkVal({tag, "_y"}, qy[n], yy);
          checkVal({tag, "_cell"}, qcell[n], cellOf(base, xx, yy, mix));
        end else begin
          checkVal({tag, "_missing_cell"}, qcell.size(), n + 1);
        end
      end
    end
  endtask

  // Hold out_ready low for 5 cycles once the first cell shows up
  task automatic stallCtl();
    int g;
    g = 0;
    while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
    if (!out_valid) checkVal("t2_cell_timeout", out_valid, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkVal("t2_stall_in_ready", in_ready, 0);
      checkVal("t2_stall_vld", out_valid, 1);
      checkVal("t2_stall_cell", out_cell, firstCell);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    firstCell = 216'h222222_212121_202020_121212_111111_101010_020202_010101_000000;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    checkVal("rst_out_valid", out_valid, 0);
    checkVal("rst_out_cell", out_cell, 0);
    checkVal("rst_out_x", out_x, 0);
    checkVal("rst_out_y", out_y, 0);
    checkVal("rst_frame_done", frame_done, 0);
    checkVal("rst_in_ready", in_ready, 1);
`ifdef CELL_WINDOW_FRAME_ERR_EN
    checkVal("rst_frame_err", frame_err, 0);
    checkVal("rst_err_count", err_count, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: one frame, free-flowing output, latency and hand-computed first cell
    clearMon();
    sendRange(0, 0, 9, 1'b1, 1'b0, 1'b0);
    checkVal("t1_no_cell_before_2_2", out_valid, 0);
    sendRange(0, 10, 10, 1'b0, 1'b0, 1'b0);
    checkVal("t1_latency_vld", out_valid, 1);
    checkVal("t1_latency_x", out_x, 1);
    checkVal("t1_latency_y", out_y, 1);
    checkVal("t1_first_cell", out_cell, firstCell);
    sendRange(0, 11, 15, 1'b0, 1'b0, 1'b0);
    idle(5);
    checkVal("t1_cell_count", qcell.size(), 4);
    checkFrameCells("t1", 0, 0, 1'b0);
    checkVal("t1_frame_done_count", fdPos.size(), 1);
    if (fdPos.size() > 0) checkVal("t1_frame_done_pos", fdPos[0], 4);
`ifdef CELL_WINDOW_FRAME_ERR_EN
    checkVal("t1_no_frame_err", errPulses, 0);
`endif

    // Test 2: downstream stall on the first cell
    clearMon();
    fork
      sendRange(0, 0, 15, 1'b1, 1'b0, 1'b0);
      stallCtl();
    join
    idle(5);
    checkVal("t2_cell_count", qcell.size(), 4);
    checkFrameCells("t2", 0, 0, 1'b0);
    checkVal("t2_frame_done_count", fdPos.size(), 1);

    // Test 3: two frames back-to-back, second without in_sof
    clearMon();
    sendRange(0, 0, 15, 1'b1, 1'b0, 1'b0);
    sendRange(8'h80, 0, 15, 1'b0, 1'b0, 1'b0);
    idle(5);
    checkVal("t3_cell_count", qcell.size(), 8);
    checkFrameCells("t3f0", 0, 0, 1'b0);
    checkFrameCells("t3f1", 4, 8'h80, 1'b0);
    checkVal("t3_frame_done_count", fdPos.size(), 2);
    if (fdPos.size() > 1) checkVal("t3_frame_done_pos2", fdPos[1], 8);

    // Test 4: in_sof at pixel (1,2) abandons the partial frame
    clearMon();
    sendRange(0, 0, 8, 1'b1, 1'b0, 1'b0);
    sendRange(8'h40, 0, 15, 1'b1, 1'b0, 1'b0);
    idle(5);
    checkVal("t4_cell_count", qcell.size(), 4);
    checkFrameCells("t4", 0, 8'h40, 1'b0);
    checkVal("t4_frame_done_count", fdPos.size(), 1);
`ifdef CELL_WINDOW_FRAME_ERR_EN
    checkVal("t4_frame_err_pulses", errPulses, 1);
    checkVal("t4_err_count", err_count, 1);
`endif

    // Test 5: reset while a cell is pending, then a frame without in_sof
    clearMon();
    sendRange(0, 0, 10, 1'b1, 1'b0, 1'b0);
    checkVal("t5_vld_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkVal("t5_rst_vld", out_valid, 0);
    checkVal("t5_rst_x", out_x, 0);
    checkVal("t5_rst_y", out_y, 0);
    checkVal("t5_rst_cell", out_cell, 0);
`ifdef CELL_WINDOW_FRAME_ERR_EN
    checkVal("t5_rst_err_count", err_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clearMon();
    sendRange(0, 0, 15, 1'b0, 1'b0, 1'b0);
    idle(5);
    checkVal("t5_cell_count", qcell.size(), 4);
    checkFrameCells("t5", 0, 0, 1'b0);
    checkVal("t5_frame_done_count", fdPos.size(), 1);

    // Test 6: random in_valid gaps and out_ready toggling over three frames
    clearMon();
    drvDone = 1'b0;
    fork
      begin
        sendRange(8'h00, 0, 15, 1'b1, 1'b1, 1'b1);
        sendRange(8'h40, 0, 15, 1'b0, 1'b1, 1'b1);
        sendRange(8'h80, 0, 15, 1'b0, 1'b1, 1'b1);
        drvDone = 1'b1;
      end
      begin
        while (!drvDone) begin
          out_ready = 1'($urandom_range(1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    checkVal("t6_cell_count", qcell.size(), 12);
    checkFrameCells("t6f0", 0, 8'h00, 1'b1);
    checkFrameCells("t6f1", 4, 8'h40, 1'b1);
    checkFrameCells("t6f2", 8, 8'h80, 1'b1);
    checkVal("t6_frame_done_count", fdPos.size(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
